// File: rtl/value_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : value_router_pkg
//  Description : Shared types and defaults for the value_router node.
//  Revision    : 1.0  initial release
// ============================================================================
package value_router_pkg;

    localparam int          DATA_W_DEF    = 32;
    localparam int          CNT_W_DEF     = 8;
    localparam logic [31:0] EMPTY_VAL_DEF = 32'hFFFF_FFFF;

    // Operation select; encodings 3'b100..3'b111 all behave as IDLE.
    typedef enum logic [2:0] {
        INSERT = 3'b000,
        INC    = 3'b001,
        REMOVE = 3'b010,
        DEC    = 3'b011,
        IDLE   = 3'b100
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/value_router_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : value_router_cmp
//  Description : Combinational compare/select for sorted-queue insertion.
//                Larger value (or any value over an empty node) takes the
//                node; the displaced value is passed on.
//  Revision    : 1.0  initial release
// ============================================================================
module value_router_cmp
    import value_router_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] EMPTY_VAL = EMPTY_VAL_DEF
) (
    input  logic [DATA_W-1:0] i_bram_out,
    input  logic [DATA_W-1:0] i_reg_out,
    output logic              o_swap,
    output logic [DATA_W-1:0] o_insert_val,
    output logic [DATA_W-1:0] o_pass_val
);

    // Unsigned compare; an empty node always accepts the incoming value.
    always_comb begin
        o_swap       = (i_bram_out == EMPTY_VAL) || (i_reg_out > i_bram_out);
        o_insert_val = o_swap ? i_reg_out  : i_bram_out;
        o_pass_val   = o_swap ? i_bram_out : i_reg_out;
    end

endmodule
`default_nettype wire

// File: rtl/value_router.sv
`default_nettype none
// ============================================================================
//  Module      : value_router
//  Description : One node of a sorted hardware queue. Performs insert,
//                remove and occupancy inc/dec; all outputs registered.
//  Revision    : 1.0  initial release
// ============================================================================
module value_router
    import value_router_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                CNT_W     = CNT_W_DEF,
    parameter logic [DATA_W-1:0] EMPTY_VAL = EMPTY_VAL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bram_out,
    input  logic [DATA_W-1:0] reg_out,
    input  logic [2:0]        mode,
    input  logic [CNT_W-1:0]  array_size,
    input  logic [CNT_W-1:0]  array_cnt_in,
    output logic [DATA_W-1:0] bram_insert,
    output logic [DATA_W-1:0] to_register,
    output logic [DATA_W-1:0] data_lt_o,
    output logic [CNT_W-1:0]  array_cnt_out,
    output logic              result,
    output logic              full,
    output logic              empty
);

    logic              w_swap;
    logic [DATA_W-1:0] w_insert_val;
    logic [DATA_W-1:0] w_pass_val;

    logic [DATA_W-1:0] r_bram_insert, w_bram_insert;
    logic [DATA_W-1:0] r_to_register, w_to_register;
    logic [DATA_W-1:0] r_data_lt,     w_data_lt;
    logic [CNT_W-1:0]  r_cnt,         w_cnt;
    logic              r_result,      w_result;
    logic              r_full,        w_full;
    logic              r_empty,       w_empty;

    value_router_cmp #(
        .DATA_W    (DATA_W),
        .EMPTY_VAL (EMPTY_VAL)
    ) u_cmp (
        .i_bram_out   (bram_out),
        .i_reg_out    (reg_out),
        .o_swap       (w_swap),
        .o_insert_val (w_insert_val),
        .o_pass_val   (w_pass_val)
    );

    // Next-state selection per mode; anything not named holds its value.
    always_comb begin
        w_bram_insert = r_bram_insert;
        w_to_register = r_to_register;
        w_data_lt     = r_data_lt;
        w_cnt         = r_cnt;
        w_result      = 1'b0;
        case (mode)
            INSERT: begin
                w_bram_insert = w_insert_val;
                w_to_register = w_pass_val;
                w_result      = w_swap;
                w_cnt         = array_cnt_in;
            end
            INC: begin
                // Saturate at capacity; a zero-size queue never counts up.
                w_cnt = (array_cnt_in >= array_size) ? array_cnt_in
                                                     : array_cnt_in + CNT_W'(1);
            end
            REMOVE: begin
                w_data_lt     = bram_out;
                w_bram_insert = reg_out;
                w_to_register = EMPTY_VAL;
                w_result      = (bram_out != EMPTY_VAL);
                w_cnt         = array_cnt_in;
            end
            DEC: begin
                w_cnt = (array_cnt_in == '0) ? '0 : array_cnt_in - CNT_W'(1);
            end
            default: ;
        endcase
        w_full  = (w_cnt >= array_size);
        w_empty = (w_cnt == '0);
    end

    // Output registers with asynchronous reset to the empty-node state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bram_insert <= EMPTY_VAL;
            r_to_register <= EMPTY_VAL;
            r_data_lt     <= EMPTY_VAL;
            r_cnt         <= '0;
            r_result      <= 1'b0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
        end else begin
            r_bram_insert <= w_bram_insert;
            r_to_register <= w_to_register;
            r_data_lt     <= w_data_lt;
            r_cnt         <= w_cnt;
            r_result      <= w_result;
            r_full        <= w_full;
            r_empty       <= w_empty;
        end
    end

    assign bram_insert   = r_bram_insert;
    assign to_register   = r_to_register;
    assign data_lt_o     = r_data_lt;
    assign array_cnt_out = r_cnt;
    assign result        = r_result;
    assign full          = r_full;
    assign empty         = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_value_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_value_router
//  Description : Directed self-checking bench for value_router.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_value_router;

    logic        clk;
    logic        rst;
    logic [31:0] bram_out;
    logic [31:0] reg_out;
    logic [2:0]  mode;
    logic [7:0]  array_size;
    logic [7:0]  array_cnt_in;
    logic [31:0] bram_insert;
    logic [31:0] to_register;
    logic [31:0] data_lt_o;
    logic [7:0]  array_cnt_out;
    logic        result;
    logic        full;
    logic        empty;

    int n_total = 0;
    int n_bad   = 0;

    value_router dut (
        .clk           (clk),
        .rst           (rst),
        .bram_out      (bram_out),
        .reg_out       (reg_out),
        .mode          (mode),
        .array_size    (array_size),
        .array_cnt_in  (array_cnt_in),
        .bram_insert   (bram_insert),
        .to_register   (to_register),
        .data_lt_o     (data_lt_o),
        .array_cnt_out (array_cnt_out),
        .result        (result),
        .full          (full),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Apply one operation, clock it in, sample 1 time unit after the edge.
    task automatic step(input logic [2:0] m, input logic [31:0] b, input logic [31:0] r,
                        input logic [7:0] c, input logic [7:0] s);
        mode         = m;
        bram_out     = b;
        reg_out      = r;
        array_cnt_in = c;
        array_size   = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        mode         = 3'b100;
        bram_out     = 32'h0;
        reg_out      = 32'h0;
        array_cnt_in = 8'd0;
        array_size   = 8'd5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bi",    bram_insert,   32'hFFFF_FFFF);
        check("rst_tr",    to_register,   32'hFFFF_FFFF);
        check("rst_lt",    data_lt_o,     32'hFFFF_FFFF);
        check("rst_cnt",   {24'h0, array_cnt_out}, 32'd0);
        check("rst_res",   {31'h0, result}, 32'd0);
        check("rst_full",  {31'h0, full},   32'd0);
        check("rst_empty", {31'h0, empty},  32'd1);
        rst = 1'b0;

        // Insert into empty node, then count up.
        step(3'b000, 32'hFFFF_FFFF, 32'h2, 8'd0, 8'd5);
        check("ins1_bi",  bram_insert, 32'h2);
        check("ins1_tr",  to_register, 32'hFFFF_FFFF);
        check("ins1_res", {31'h0, result}, 32'd1);
        check("ins1_emp", {31'h0, empty},  32'd1);
        step(3'b001, 32'h0, 32'h0, 8'd0, 8'd5);
        check("inc1_cnt", {24'h0, array_cnt_out}, 32'd1);
        check("inc1_emp", {31'h0, empty},  32'd0);
        check("inc1_res", {31'h0, result}, 32'd0);
        check("inc1_bi",  bram_insert, 32'h2);

        // Smaller incoming value stays put.
        step(3'b000, 32'h2, 32'h1, 8'd1, 8'd5);
        check("ins2_bi",  bram_insert, 32'h2);
        check("ins2_tr",  to_register, 32'h1);
        check("ins2_res", {31'h0, result}, 32'd0);

        // Equal values: no swap.
        step(3'b000, 32'h5, 32'h5, 8'd1, 8'd5);
        check("eq_res",  {31'h0, result}, 32'd0);
        check("eq_tr",   to_register, 32'h5);

        // Large values near the top of range, then fill to capacity.
        step(3'b000, 32'hF657_C062, 32'hF680_D628, 8'd4, 8'd5);
        check("ins3_bi",  bram_insert, 32'hF680_D628);
        check("ins3_tr",  to_register, 32'hF657_C062);
        check("ins3_res", {31'h0, result}, 32'd1);
        step(3'b001, 32'h0, 32'h0, 8'd4, 8'd5);
        check("inc4_cnt",  {24'h0, array_cnt_out}, 32'd5);
        check("inc4_full", {31'h0, full}, 32'd1);
        step(3'b001, 32'h0, 32'h0, 8'd5, 8'd5);
        check("inc5_cnt",  {24'h0, array_cnt_out}, 32'd5);
        check("inc5_full", {31'h0, full}, 32'd1);

        // Remove, then count down.
        step(3'b010, 32'h39B0_34AC, 32'h39B0_34AB, 8'd2, 8'd5);
        check("rem_lt",  data_lt_o,   32'h39B0_34AC);
        check("rem_bi",  bram_insert, 32'h39B0_34AB);
        check("rem_tr",  to_register, 32'hFFFF_FFFF);
        check("rem_res", {31'h0, result}, 32'd1);
        check("rem_cnt", {24'h0, array_cnt_out}, 32'd2);
        step(3'b011, 32'h0, 32'h0, 8'd2, 8'd5);
        check("dec2_cnt", {24'h0, array_cnt_out}, 32'd1);
        check("dec2_lt",  data_lt_o, 32'h39B0_34AC);
        step(3'b011, 32'h0, 32'h0, 8'd1, 8'd5);
        check("dec1_cnt", {24'h0, array_cnt_out}, 32'd0);
        check("dec1_emp", {31'h0, empty}, 32'd1);
        step(3'b011, 32'h0, 32'h0, 8'd0, 8'd5);
        check("dec0_cnt", {24'h0, array_cnt_out}, 32'd0);
        check("dec0_emp", {31'h0, empty}, 32'd1);
        step(3'b010, 32'hFFFF_FFFF, 32'h7, 8'd0, 8'd5);
        check("remE_res", {31'h0, result}, 32'd0);
        check("remE_bi",  bram_insert, 32'h7);

        // Idle holds data and count, clears result.
        step(3'b000, 32'h10, 32'h20, 8'd3, 8'd5);
        step(3'b110, 32'h99, 32'h88, 8'd1, 8'd5);
        check("idle_bi",  bram_insert, 32'h20);
        check("idle_tr",  to_register, 32'h10);
        check("idle_cnt", {24'h0, array_cnt_out}, 32'd3);
        check("idle_res", {31'h0, result}, 32'd0);

        // Zero capacity: full and empty together, INC is a no-op.
        step(3'b001, 32'h0, 32'h0, 8'd0, 8'd0);
        check("sz0_cnt",   {24'h0, array_cnt_out}, 32'd0);
        check("sz0_full",  {31'h0, full},  32'd1);
        check("sz0_empty", {31'h0, empty}, 32'd1);

        // Asynchronous reset mid-operation, no clock edge needed.
        step(3'b000, 32'hFFFF_FFFF, 32'h3, 8'd2, 8'd5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_bi",  bram_insert, 32'hFFFF_FFFF);
        check("arst_cnt", {24'h0, array_cnt_out}, 32'd0);
        check("arst_emp", {31'h0, empty}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step(3'b000, 32'h8, 32'h9, 8'd0, 8'd5);
        check("post_bi",  bram_insert, 32'h9);
        check("post_lt",  data_lt_o, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/value_router.md
VALUE_ROUTER -- requirements
Module: value_router

Interface
REQ-001 SHALL have parameter DATA_W, default 32, key/value width.
REQ-002 SHALL have parameter CNT_W, default 8, occupancy counter width.
REQ-003 SHALL have parameter EMPTY_VAL, default 32'hFFFF_FFFF, sentinel marking an unoccupied node.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bram_out  in  DATA_W  value currently stored at this node.
- reg_out  in  DATA_W  value arriving from the neighbouring register.
- mode  in  3  operation select.
- array_size  in  CNT_W  queue capacity.
- array_cnt_in  in  CNT_W  current occupancy.
- bram_insert  out  DATA_W  value to write back to this node.
- to_register  out  DATA_W  value passed on to the next node.
- data_lt_o  out  DATA_W  value passed back to the previous node on removal.
- array_cnt_out  out  CNT_W  updated occupancy.
- result  out  1  swap/valid flag.
- full  out  1  occupancy has reached capacity.
- empty  out  1  occupancy is zero.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-006 SHALL register all outputs: inputs sampled on rising clk edge N appear on the outputs after edge N; latency is 1 cycle.
REQ-007 SHALL compute swap = (bram_out == EMPTY_VAL) OR (reg_out > bram_out), using an unsigned DATA_W compare.
REQ-008 mode 3'b000 (INSERT) SHALL apply:
- bram_insert = swap ? reg_out : bram_out.
- to_register = swap ? bram_out : reg_out.
- result = swap.
- array_cnt_out = array_cnt_in.
REQ-009 mode 3'b001 (INC) SHALL set array_cnt_out = array_cnt_in+1, saturating at array_size (no increment when array_cnt_in >= array_size).
REQ-010 mode 3'b010 (REMOVE) SHALL apply:
- data_lt_o = bram_out.
- bram_insert = reg_out.
- to_register = EMPTY_VAL.
- result = (bram_out != EMPTY_VAL).
- array_cnt_out = array_cnt_in.
REQ-011 mode 3'b011 (DEC) SHALL set array_cnt_out = array_cnt_in-1, saturating at 0 (no wrap below zero).
REQ-012 In INC and DEC, bram_insert, to_register and data_lt_o SHALL hold their previous values, and result SHALL be 0.
REQ-013 modes 3'b100..3'b111 (IDLE) SHALL hold all data outputs and array_cnt_out and force result=0.
REQ-014 full SHALL be (next array_cnt_out >= array_size) and empty SHALL be (next array_cnt_out == 0), registered together with array_cnt_out.
REQ-015 array_size = 0 SHALL yield full=1 and empty=1, and INC SHALL not change the count.
REQ-016 Counter arithmetic SHALL be CNT_W bits unsigned, with the saturation rules above and no overflow wrap.

Reset
REQ-017 While rst=1, outputs SHALL be forced to: bram_insert, to_register, data_lt_o = EMPTY_VAL; array_cnt_out=0; result=0; full=0; empty=1.
REQ-018 Reset asserted mid-operation SHALL override any mode in the same cycle; the first operation after release SHALL use only that cycle's inputs.

Structure
REQ-019 Package value_router_pkg SHALL hold the mode enum (INSERT, INC, REMOVE, DEC, IDLE), EMPTY_VAL and the default widths.
REQ-020 The compare/select datapath SHALL be one sub-module, value_router_cmp, that is purely combinational and produces swap, the insert value and the pass-on value.

Verification
REQ-021 Reset -> all data outputs 32'hFFFF_FFFF, cnt 0, empty=1, full=0.
REQ-022 size 5, cnt 0, bram FFFF_FFFF, reg 2, INSERT -> bram_insert 2, to_register FFFF_FFFF, result 1; then INC -> cnt 1, empty 0.
REQ-023 bram 2, reg 1, INSERT -> bram_insert 2, to_register 1, result 0.
REQ-024 cnt 4, size 5, bram F657_C062, reg F680_D628, INSERT -> bram_insert F680_D628, to_register F657_C062, result 1; INC -> cnt 5, full 1; a second INC -> cnt stays 5.
REQ-025 cnt 2, bram 39B0_34AC, reg 39B0_34AB, REMOVE -> data_lt_o 39B0_34AC, bram_insert 39B0_34AB, result 1; DEC -> cnt 1.
REQ-026 DEC from cnt 1 -> cnt 0, empty 1; another DEC -> cnt stays 0; REMOVE with bram FFFF_FFFF -> result 0.
